// File: rtl/mux8_rr_sched.sv
// Round-robin scheduler for a shared 8:1 single-bit mux channel.
// Grants are held for a bounded tenure and separated by one idle cycle.
module mux8_rr_sched #(
    parameter int MAX_HOLD = 4,
    parameter int CNT_W    = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] req,
    input  logic [7:0] din,
    output logic [2:0] sel,
    output logic [7:0] grant,
    output logic       valid,
    output logic       dout
);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t           state, state_n;
    logic [2:0]       ptr, ptr_n;
    logic [2:0]       sel_n;
    logic [2:0]       win;
    logic             found;
    logic [7:0]       grant_n;
    logic             valid_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic             rel;

    // Scan ptr+1 .. ptr+8; the last offset wraps back onto ptr itself.
    always_comb begin
        win   = ptr;
        found = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            if (!found && req[ptr + 3'(k)]) begin
                win   = ptr + 3'(k);
                found = 1'b1;
            end
        end
    end

    assign rel = !req[sel] || (cnt == CNT_W'(MAX_HOLD - 1));

    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        sel_n   = sel;
        grant_n = grant;
        valid_n = valid;
        cnt_n   = cnt;
        unique case (state)
            IDLE: begin
                grant_n = 8'h00;
                valid_n = 1'b0;
                if (found) begin
                    state_n = GRANT;
                    sel_n   = win;
                    grant_n = 8'h01 << win;
                    valid_n = 1'b1;
                    cnt_n   = '0;
                    ptr_n   = win;
                end
            end
            GRANT: begin
                if (rel) begin
                    state_n = IDLE;
                    grant_n = 8'h00;
                    valid_n = 1'b0;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
                grant_n = 8'h00;
                valid_n = 1'b0;
                cnt_n   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            ptr   <= 3'd7;
            sel   <= 3'd0;
            grant <= 8'h00;
            valid <= 1'b0;
            cnt   <= '0;
        end else begin
            state <= state_n;
            ptr   <= ptr_n;
            sel   <= sel_n;
            grant <= grant_n;
            valid <= valid_n;
            cnt   <= cnt_n;
        end
    end

    // Gating with valid keeps the shared line quiet between tenures.
    assign dout = valid & din[sel];

endmodule

// File: tb/tb_mux8_rr_sched.sv
// Randomized and directed checks of mux8_rr_sched against a tenure-level
// model of the round-robin policy.
module tb_mux8_rr_sched;

    localparam int MH = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] req;
    logic [7:0] din;
    logic [2:0] sel;
    logic [7:0] grant;
    logic       valid;
    logic       dout;

    int errors = 0;
    int checks = 0;

    bit         m_busy = 1'b0;
    int         m_owner = 0;
    int         m_last = 7;
    int         m_used = 0;
    logic [2:0] m_sel = 3'd0;

    mux8_rr_sched #(.MAX_HOLD(MH), .CNT_W(8)) dut (
        .clk  (clk),
        .rst  (rst),
        .req  (req),
        .din  (din),
        .sel  (sel),
        .grant(grant),
        .valid(valid),
        .dout (dout)
    );

    always #5 clk = ~clk;

    function automatic logic [12:0] expv();
        logic [7:0] g;
        g = m_busy ? 8'(1 << m_owner) : 8'h00;
        return {m_busy, m_sel, g, m_busy & din[m_sel]};
    endfunction

    function automatic logic [12:0] obs();
        return {valid, sel, grant, dout};
    endfunction

    // Model: a tenure is a run of granted cycles owned by one requester.
    task automatic model_edge();
        int  w;
        bit  hit;
        if (rst) begin
            m_busy = 1'b0;
            m_sel  = 3'd0;
            m_last = 7;
            m_used = 0;
        end else if (!m_busy) begin
            if (req != 8'h00) begin
                w   = 0;
                hit = 1'b0;
                for (int k = 1; k <= 8; k++) begin
                    if (!hit && req[(m_last + k) % 8]) begin
                        w   = (m_last + k) % 8;
                        hit = 1'b1;
                    end
                end
                m_busy  = 1'b1;
                m_owner = w;
                m_last  = w;
                m_sel   = 3'(w);
                m_used  = 1;
            end
        end else if (!req[m_owner] || m_used == MH) begin
            m_busy = 1'b0;
            m_used = 0;
        end else begin
            m_used++;
        end
    endtask

    task automatic step(input logic r, input logic [7:0] q);
        rst = r;
        req = q;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        din = 8'hFF;
        for (int i = 0; i < 2; i++) begin
            step(1'b1, 8'hFF);
            checks++;
            if ({valid, grant, sel} !== 12'h000) begin
                errors++;
                $display("FAIL reset_hold cyc=%0d got=%h want=000",
                         i, {valid, grant, sel});
            end
        end
        step(1'b0, 8'hFF);
        checks++;
        if ({valid, sel, grant} !== {1'b1, 3'd0, 8'h01}) begin
            errors++;
            $display("FAIL reset_first got=%h want=%h",
                     {valid, sel, grant}, {1'b1, 3'd0, 8'h01});
        end
        checks++;
        if (obs() !== expv()) begin
            errors++;
            $display("FAIL reset_model got=%h want=%h", obs(), expv());
        end
    endtask

    task automatic test_single();
        int on;
        step(1'b1, 8'h00);
        din = 8'h20;
        on  = 0;
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 8'h20);
            on = valid ? on + 1 : on;
            checks++;
            if (obs() !== expv()) begin
                errors++;
                $display("FAIL single cyc=%0d got=%h want=%h",
                         i, obs(), expv());
            end
            if (i == MH) begin
                checks++;
                if (on !== MH || valid !== 1'b0) begin
                    errors++;
                    $display("FAIL single_len got=%0d/%b want=%0d/0",
                             on, valid, MH);
                end
            end
        end
    endtask

    task automatic test_contention();
        int n_ten;
        logic [2:0] exp_sel;
        logic       pv;
        step(1'b1, 8'h00);
        exp_sel = 3'd0;
        pv      = 1'b0;
        n_ten   = 0;
        for (int i = 0; i < 3 * 8 * (MH + 1); i++) begin
            din = 8'($urandom);
            step(1'b0, 8'hFF);
            checks++;
            if (obs() !== expv()) begin
                errors++;
                $display("FAIL contend cyc=%0d got=%h want=%h",
                         i, obs(), expv());
            end
            if (valid && !pv) begin
                checks++;
                if (sel !== exp_sel) begin
                    errors++;
                    $display("FAIL contend_order ten=%0d got=%0d want=%0d",
                             n_ten, sel, exp_sel);
                end
                exp_sel = exp_sel + 3'd1;
                n_ten++;
            end
            pv = valid;
        end
    endtask

    task automatic test_early();
        logic [7:0] seq [5];
        seq = '{8'h08, 8'h48, 8'h40, 8'h40, 8'h40};
        step(1'b1, 8'h00);
        din = 8'h48;
        for (int i = 0; i < 5; i++) begin
            step(1'b0, seq[i]);
            checks++;
            if (obs() !== expv()) begin
                errors++;
                $display("FAIL early cyc=%0d got=%h want=%h",
                         i, obs(), expv());
            end
        end
        checks++;
        if ({sel, grant} !== {3'd6, 8'h40}) begin
            errors++;
            $display("FAIL early_next got=%h want=%h",
                     {sel, grant}, {3'd6, 8'h40});
        end
    endtask

    task automatic test_wrap();
        step(1'b1, 8'h00);
        din = 8'h41;
        step(1'b0, 8'h40);
        step(1'b0, 8'h01);
        step(1'b0, 8'h41);
        checks++;
        if ({valid, sel} !== {1'b1, 3'd0}) begin
            errors++;
            $display("FAIL wrap_first got=%h want=%h",
                     {valid, sel}, {1'b1, 3'd0});
        end
        for (int i = 0; i < MH + 1; i++) begin
            step(1'b0, 8'h41);
            checks++;
            if (obs() !== expv()) begin
                errors++;
                $display("FAIL wrap cyc=%0d got=%h want=%h",
                         i, obs(), expv());
            end
        end
        checks++;
        if ({valid, sel, grant} !== {1'b1, 3'd6, 8'h40}) begin
            errors++;
            $display("FAIL wrap_second got=%h want=%h",
                     {valid, sel, grant}, {1'b1, 3'd6, 8'h40});
        end
    endtask

    task automatic test_midreset();
        step(1'b1, 8'h00);
        din = 8'h21;
        step(1'b0, 8'h20);
        step(1'b0, 8'h20);
        step(1'b1, 8'h20);
        checks++;
        if ({valid, grant, sel} !== 12'h000) begin
            errors++;
            $display("FAIL midrst got=%h want=000", {valid, grant, sel});
        end
        for (int i = 0; i < 2 * (MH + 1); i++) begin
            step(1'b0, 8'h21);
            checks++;
            if (obs() !== expv()) begin
                errors++;
                $display("FAIL midrst_seq cyc=%0d got=%h want=%h",
                         i, obs(), expv());
            end
            if (i == 0 || i == MH + 1) begin
                checks++;
                if (sel !== (i == 0 ? 3'd0 : 3'd5) || !valid) begin
                    errors++;
                    $display("FAIL midrst_win cyc=%0d got=%0d want=%0d",
                             i, sel, i == 0 ? 0 : 5);
                end
            end
        end
    endtask

    task automatic test_random();
        logic r;
        step(1'b1, 8'h00);
        for (int i = 0; i < 600; i++) begin
            r   = ($urandom_range(0, 63) == 0);
            din = 8'($urandom);
            step(r, 8'($urandom) & 8'($urandom));
            checks++;
            if (obs() !== expv()) begin
                errors++;
                $display("FAIL rand cyc=%0d got=%h want=%h",
                         i, obs(), expv());
            end
            din = 8'($urandom);
            #1;
            checks++;
            if (dout !== (m_busy & din[m_sel])) begin
                errors++;
                $display("FAIL rand_dout cyc=%0d got=%b want=%b",
                         i, dout, m_busy & din[m_sel]);
            end
            checks++;
            if ((grant & (grant - 8'h01)) !== 8'h00
                || (valid !== (grant != 8'h00))
                || (valid && !grant[sel])) begin
                errors++;
                $display("FAIL rand_inv cyc=%0d got=%b/%h/%0d want=onehot",
                         i, valid, grant, sel);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        req = 8'h00;
        din = 8'h00;
        test_reset();
        test_single();
        test_contention();
        test_early();
        test_wrap();
        test_midreset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
